// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO block with serial shift engine:
// register offsets, SHIFT_CFG field layout, ID constant and FSM encoding.
package gpio_pkg;

    localparam logic [31:0] GPIO_ID_DEFAULT = 32'h47504932;

    localparam logic [7:0] OFF_ID         = 8'h00;
    localparam logic [7:0] OFF_CHANNELS   = 8'h04;
    localparam logic [7:0] OFF_IN         = 8'h08;
    localparam logic [7:0] OFF_DIR        = 8'h0C;
    localparam logic [7:0] OFF_OUT        = 8'h10;
    localparam logic [7:0] OFF_OUT_SET    = 8'h14;
    localparam logic [7:0] OFF_OUT_CLR    = 8'h18;
    localparam logic [7:0] OFF_RISE_EN    = 8'h1C;
    localparam logic [7:0] OFF_FALL_EN    = 8'h20;
    localparam logic [7:0] OFF_EDGE_STAT  = 8'h24;
    localparam logic [7:0] OFF_SHIFT_CFG  = 8'h28;
    localparam logic [7:0] OFF_SHIFT_DIV  = 8'h2C;
    localparam logic [7:0] OFF_SHIFT_DATA = 8'h30;
    localparam logic [7:0] OFF_SHIFT_STAT = 8'h34;

    // SHIFT_CFG field positions
    localparam int CFG_SCLK_LSB    = 0;
    localparam int CFG_MOSI_LSB    = 8;
    localparam int CFG_MISO_LSB    = 16;
    localparam int CFG_CPOL        = 24;
    localparam int CFG_LSB_FIRST   = 25;
    localparam int CFG_DONE_IRQ_EN = 26;
    localparam logic [31:0] CFG_MASK = 32'h071F_1F1F;

    typedef struct packed {
        logic       lsb_first;
        logic       cpol;
        logic [4:0] miso_pin;
        logic [4:0] mosi_pin;
        logic [4:0] sclk_pin;
    } shift_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_TRAIL = 2'd2,
        ST_DONE  = 2'd3
    } shift_state_t;

endpackage

// File: rtl/gpio_shift_core_engine.sv
// Serial shift engine: divider, bit counter, tx/rx shift registers.
// Configuration is latched at start so bus writes during a transfer only
// affect the next one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; sclk/mosi not driving pads
// ST_LEAD  | first half of a bit: sclk = cpol, mosi holds current bit
// ST_TRAIL | second half: sclk = ~cpol; miso sampled at its close
// ST_DONE  | publish rx, drop busy, pulse done
module gpio_shift_engine
    import gpio_pkg::*;
#(
    parameter int SHIFT_WIDTH = 8,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  shift_cfg_t             cfg,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [SHIFT_WIDTH-1:0] tx,
    input  logic                   miso,
    output logic                   busy,
    output logic                   done,
    output logic [SHIFT_WIDTH-1:0] rx,
    output logic                   sclk,
    output logic                   mosi,
    output logic [4:0]             sclk_pin,
    output logic [4:0]             mosi_pin,
    output logic [4:0]             miso_pin
);

    localparam int CW = $clog2(SHIFT_WIDTH + 1);

    shift_state_t           state;
    logic                   cpol_q;
    logic                   lsb_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   divcnt;
    logic [CW-1:0]          bitcnt;
    logic [SHIFT_WIDTH-1:0] tx_sh;
    logic [SHIFT_WIDTH-1:0] rx_sh;
    logic [SHIFT_WIDTH-1:0] tx_next;
    logic [SHIFT_WIDTH-1:0] rx_next;

    // Next shift-register contents for either bit order
    always_comb begin
        tx_next = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        rx_next = lsb_q ? ((rx_sh >> 1) | (SHIFT_WIDTH'(miso) << (SHIFT_WIDTH - 1)))
                        : ((rx_sh << 1) | SHIFT_WIDTH'(miso));
    end

    // Transfer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cpol_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sclk_pin <= '0;
            mosi_pin <= '0;
            miso_pin <= '0;
            div_q    <= '0;
            divcnt   <= '0;
            bitcnt   <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cpol_q   <= cfg.cpol;
                        lsb_q    <= cfg.lsb_first;
                        sclk_pin <= cfg.sclk_pin;
                        mosi_pin <= cfg.mosi_pin;
                        miso_pin <= cfg.miso_pin;
                        div_q    <= div;
                        divcnt   <= div;
                        bitcnt   <= CW'(SHIFT_WIDTH);
                        tx_sh    <= tx;
                        rx_sh    <= '0;
                        busy     <= 1'b1;
                        sclk     <= cfg.cpol;
                        mosi     <= cfg.lsb_first ? tx[0] : tx[SHIFT_WIDTH-1];
                        state    <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (divcnt == '0) begin
                        divcnt <= div_q;
                        sclk   <= ~cpol_q;
                        state  <= ST_TRAIL;
                    end else begin
                        divcnt <= divcnt - DIV_WIDTH'(1);
                    end
                end
                ST_TRAIL: begin
                    // Sampling at the close of the bit period leaves room for
                    // the pad register and the two-flop input synchroniser.
                    if (divcnt == '0) begin
                        divcnt <= div_q;
                        sclk   <= cpol_q;
                        rx_sh  <= rx_next;
                        bitcnt <= bitcnt - CW'(1);
                        if (bitcnt == CW'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            tx_sh <= tx_next;
                            mosi  <= lsb_q ? tx_next[0] : tx_next[SHIFT_WIDTH-1];
                            state <= ST_LEAD;
                        end
                    end else begin
                        divcnt <= divcnt - DIV_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    rx    <= rx_sh;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpio_shift_core.sv
// Memory-mapped GPIO: register file, input synchroniser, edge capture,
// registered pad drivers and the serial shift engine.
module gpio_shift_core
    import gpio_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter int          SHIFT_WIDTH = 8,
    parameter int          DIV_WIDTH   = 16,
    parameter logic [31:0] ID_VALUE    = GPIO_ID_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_valid,
    output logic                mem_ready,
    output logic                mem_error,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_rdata,
    input  logic [CHANNELS-1:0] pins_i,
    output logic [CHANNELS-1:0] pins_o,
    output logic [CHANNELS-1:0] pins_t,
    output logic                irq
);

    logic [CHANNELS-1:0]    sync1, sync2, in_q, prev_q;
    logic [CHANNELS-1:0]    dir_q, out_q, rise_en_q, fall_en_q, edge_stat;
    logic [31:0]            cfg_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   done_flag;

    logic                   accept, is_wr, mapped, writable, err, wr_en, start;
    logic [7:0]             off;
    logic [31:0]            rd_val;
    logic [CHANNELS-1:0]    wdata_ch, edge_set;
    logic [CHANNELS-1:0]    pad_o_next, pad_t_next;

    shift_cfg_t             eng_cfg;
    logic                   eng_busy, eng_done, eng_sclk, eng_mosi, eng_miso;
    logic [SHIFT_WIDTH-1:0] eng_rx;
    logic [4:0]             eng_sclk_pin, eng_mosi_pin, eng_miso_pin;

    assign accept   = mem_valid && !mem_ready;
    assign is_wr    = (mem_wstrb != 4'b0000);
    assign off      = mem_addr[7:0];
    assign wdata_ch = mem_wdata[CHANNELS-1:0];

    // Address decode and read mux
    always_comb begin
        rd_val   = '0;
        mapped   = 1'b1;
        writable = 1'b1;
        case (off)
            OFF_ID:         begin rd_val = ID_VALUE;          writable = 1'b0; end
            OFF_CHANNELS:   begin rd_val = 32'(CHANNELS);     writable = 1'b0; end
            OFF_IN:         begin rd_val = 32'(in_q);         writable = 1'b0; end
            OFF_DIR:        rd_val = 32'(dir_q);
            OFF_OUT:        rd_val = 32'(out_q);
            OFF_OUT_SET:    rd_val = '0;
            OFF_OUT_CLR:    rd_val = '0;
            OFF_RISE_EN:    rd_val = 32'(rise_en_q);
            OFF_FALL_EN:    rd_val = 32'(fall_en_q);
            OFF_EDGE_STAT:  rd_val = 32'(edge_stat);
            OFF_SHIFT_CFG:  rd_val = cfg_q;
            OFF_SHIFT_DIV:  rd_val = 32'(div_q);
            OFF_SHIFT_DATA: rd_val = 32'(eng_rx);
            OFF_SHIFT_STAT: rd_val = {30'b0, done_flag, eng_busy};
            default:        begin mapped = 1'b0; writable = 1'b0; end
        endcase
        if (mem_addr[31:8] != 24'b0 || mem_addr[1:0] != 2'b00) begin
            mapped   = 1'b0;
            writable = 1'b0;
        end
    end

    assign err   = !mapped || (is_wr && (mem_wstrb != 4'b1111 || !writable ||
                   (off == OFF_SHIFT_DATA && eng_busy)));
    assign wr_en = accept && is_wr && !err;
    assign start = wr_en && (off == OFF_SHIFT_DATA);

    // Bus response: one-cycle ready strobe with error and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_error <= accept && err;
            mem_rdata <= (accept && !err && !is_wr) ? rd_val : 32'b0;
        end
    end

    // Writable configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            cfg_q     <= '0;
            div_q     <= '0;
        end else if (wr_en) begin
            case (off)
                OFF_DIR:       dir_q     <= wdata_ch;
                OFF_OUT:       out_q     <= wdata_ch;
                OFF_OUT_SET:   out_q     <= out_q | wdata_ch;
                OFF_OUT_CLR:   out_q     <= out_q & ~wdata_ch;
                OFF_RISE_EN:   rise_en_q <= wdata_ch;
                OFF_FALL_EN:   fall_en_q <= wdata_ch;
                OFF_SHIFT_CFG: cfg_q     <= mem_wdata & CFG_MASK;
                OFF_SHIFT_DIV: div_q     <= mem_wdata[DIV_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser, IN register and one-cycle history for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            in_q   <= '0;
            prev_q <= '0;
        end else begin
            sync1  <= pins_i;
            sync2  <= sync1;
            in_q   <= sync2;
            prev_q <= in_q;
        end
    end

    assign edge_set = (in_q & ~prev_q & rise_en_q) | (~in_q & prev_q & fall_en_q);

    // Sticky status bits; a hardware set beats a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_stat <= '0;
            done_flag <= 1'b0;
        end else begin
            edge_stat <= (edge_stat & ~((wr_en && off == OFF_EDGE_STAT) ? wdata_ch : '0))
                         | edge_set;
            done_flag <= (done_flag & ~(wr_en && off == OFF_SHIFT_STAT && mem_wdata[1]))
                         | eng_done;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (|edge_stat) | (done_flag & cfg_q[CFG_DONE_IRQ_EN]);
    end

    // Engine pins override OUT/DIR while busy; out-of-range indices never match
    always_comb begin
        pad_o_next = out_q;
        pad_t_next = ~dir_q;
        eng_miso   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (eng_busy && eng_mosi_pin == 5'(i)) begin
                pad_o_next[i] = eng_mosi;
                pad_t_next[i] = 1'b0;
            end
            if (eng_busy && eng_sclk_pin == 5'(i)) begin
                pad_o_next[i] = eng_sclk;
                pad_t_next[i] = 1'b0;
            end
            if (eng_miso_pin == 5'(i)) eng_miso = sync2[i];
        end
    end

    // Registered pad drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_o <= '0;
            pins_t <= '1;
        end else begin
            pins_o <= pad_o_next;
            pins_t <= pad_t_next;
        end
    end

    assign eng_cfg = '{lsb_first: cfg_q[CFG_LSB_FIRST],
                       cpol:      cfg_q[CFG_CPOL],
                       miso_pin:  cfg_q[CFG_MISO_LSB +: 5],
                       mosi_pin:  cfg_q[CFG_MOSI_LSB +: 5],
                       sclk_pin:  cfg_q[CFG_SCLK_LSB +: 5]};

    gpio_shift_engine #(
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .DIV_WIDTH   (DIV_WIDTH)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg      (eng_cfg),
        .div      (div_q),
        .tx       (mem_wdata[SHIFT_WIDTH-1:0]),
        .miso     (eng_miso),
        .busy     (eng_busy),
        .done     (eng_done),
        .rx       (eng_rx),
        .sclk     (eng_sclk),
        .mosi     (eng_mosi),
        .sclk_pin (eng_sclk_pin),
        .mosi_pin (eng_mosi_pin),
        .miso_pin (eng_miso_pin)
    );

endmodule
